// File: rtl/cpu_pkg.sv
// Shared types and widths for the simple microprocessor.
// Imported by the fetch stage and its neighbours.
package cpu_pkg;

  localparam int INSTR_BYTES = 3;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int INSTR_W     = 24;

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4,
    CLEAR  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: walks the PC over byte RAM, packs 3 bytes
// into one instruction, and offers it to the decoder.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               mem_clear,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  input  logic               clear_req
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] byte0;
  logic [DATA_W-1:0] byte1;
  logic              xfer;
  logic              active;

  assign xfer   = instr_valid && instr_ready;
  assign active = (state != HALTED) && (state != CLEAR);

  always_comb begin
    mem_addr = pc;
    unique case (state)
      FETCH1:  mem_addr = pc + 16'd1;
      FETCH2:  mem_addr = pc + 16'd2;
      default: mem_addr = pc;
    endcase
  end

  assign mem_clear = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH0;
      pc          <= RESET_PC;
      byte0       <= '0;
      byte1       <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (clear_req) begin
      state       <= CLEAR;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
    end else if (state == CLEAR) begin
      state <= FETCH0;
    end else if (!active) begin
      state <= HALTED;
    end else if (halt) begin
      // A transfer on the same edge still retires its instruction.
      state       <= HALTED;
      instr_valid <= 1'b0;
      if (xfer) pc <= pc + 16'd3;
    end else if (jump_en) begin
      state       <= FETCH0;
      pc          <= jump_addr;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH0: begin
          byte0 <= mem_data;
          state <= FETCH1;
        end
        FETCH1: begin
          byte1 <= mem_data;
          state <= FETCH2;
        end
        FETCH2: begin
          instr       <= {byte0, byte1, mem_data};
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (xfer) begin
            pc          <= pc + 16'd3;
            instr_valid <= 1'b0;
            state       <= FETCH0;
          end
        end
        default: state <= FETCH0;
      endcase
    end
  end

endmodule
